// File: rtl/rx_8b10b_deframer.sv
// Receive deframer: 8b/10b decode with running-disparity tracking, K.28.1 sync hunt,
// payload delivery and K.23.7 + little-endian CRC-32 trailer check. All outputs registered.
module rx_8b10b_deframer #(
    parameter int unsigned SYNC_LEN = 4,
    parameter logic [31:0] CRC_INIT = 32'hFFFF_FFFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pushin,
    input  logic [9:0] datain,
    input  logic       startin,
    output logic       pushout,
    output logic [8:0] dataout,
    output logic       startout,
    output logic       endout,
    output logic       crc_err,
    output logic       sym_err,
    output logic       disp_err
);
    localparam int unsigned CW = $clog2(SYNC_LEN + 1);

    typedef enum logic [2:0] {StHunt, StSync, StData, StCrcb, StTerm} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_rd;
    logic [31:0]   r_crc, r_rx_crc;
    logic [1:0]    r_idx;
    logic          r_pushout, r_startout, r_endout, r_crc_err, r_sym_err, r_disp_err;
    logic [8:0]    r_dataout;

    logic [5:0]    w_6b;
    logic [3:0]    w_4b, w_4k;
    logic [2:0]    w_n6, w_n4;
    logic [4:0]    w_x;
    logic [2:0]    w_y;
    logic [7:0]    w_byte;
    logic          w_6ok, w_4ok, w_k28, w_k, w_rd6, w_rd4, w_dbad, w_sbad;
    logic          w_is_sync, w_is_eop, w_is_crcmk, w_open;
    state_t        w_st;
    logic [CW-1:0] w_cnt, w_cnt_inc;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'd0, b};
        for (int n = 0; n < 8; n++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    assign w_6b = datain[9:4];
    assign w_4b = datain[3:0];
    assign w_n6 = 3'($countones(w_6b));
    assign w_n4 = 3'($countones(w_4b));
    // K.28 4b codes after 110000 are the complement of those after 001111
    assign w_4k = (w_6b == 6'b110000) ? ~w_4b : w_4b;

    always_comb begin
        w_6ok = 1'b1;
        w_x   = 5'd0;
        w_k28 = 1'b0;
        case (w_6b)
            6'b100111, 6'b011000: w_x = 5'd0;
            6'b011101, 6'b100010: w_x = 5'd1;
            6'b101101, 6'b010010: w_x = 5'd2;
            6'b110001:            w_x = 5'd3;
            6'b110101, 6'b001010: w_x = 5'd4;
            6'b101001:            w_x = 5'd5;
            6'b011001:            w_x = 5'd6;
            6'b111000, 6'b000111: w_x = 5'd7;
            6'b111001, 6'b000110: w_x = 5'd8;
            6'b100101:            w_x = 5'd9;
            6'b010101:            w_x = 5'd10;
            6'b110100:            w_x = 5'd11;
            6'b001101:            w_x = 5'd12;
            6'b101100:            w_x = 5'd13;
            6'b011100:            w_x = 5'd14;
            6'b010111, 6'b101000: w_x = 5'd15;
            6'b011011, 6'b100100: w_x = 5'd16;
            6'b100011:            w_x = 5'd17;
            6'b010011:            w_x = 5'd18;
            6'b110010:            w_x = 5'd19;
            6'b001011:            w_x = 5'd20;
            6'b101010:            w_x = 5'd21;
            6'b011010:            w_x = 5'd22;
            6'b111010, 6'b000101: w_x = 5'd23;
            6'b110011, 6'b001100: w_x = 5'd24;
            6'b100110:            w_x = 5'd25;
            6'b010110:            w_x = 5'd26;
            6'b110110, 6'b001001: w_x = 5'd27;
            6'b001110:            w_x = 5'd28;
            6'b101110, 6'b010001: w_x = 5'd29;
            6'b011110, 6'b100001: w_x = 5'd30;
            6'b101011, 6'b010100: w_x = 5'd31;
            6'b001111, 6'b110000: begin w_x = 5'd28; w_k28 = 1'b1; end
            default:              w_6ok = 1'b0;
        endcase

        w_4ok = 1'b1;
        w_y   = 3'd0;
        w_k   = w_k28;
        if (w_k28) begin
            case (w_4k)
                4'b0100: w_y = 3'd0;
                4'b1001: w_y = 3'd1;
                4'b0101: w_y = 3'd2;
                4'b0011: w_y = 3'd3;
                4'b0010: w_y = 3'd4;
                4'b1010: w_y = 3'd5;
                4'b0110: w_y = 3'd6;
                4'b1000: w_y = 3'd7;
                default: w_4ok = 1'b0;
            endcase
        end else begin
            case (w_4b)
                4'b1011, 4'b0100: w_y = 3'd0;
                4'b1001:          w_y = 3'd1;
                4'b0101:          w_y = 3'd2;
                4'b1100, 4'b0011: w_y = 3'd3;
                4'b1101, 4'b0010: w_y = 3'd4;
                4'b1010:          w_y = 3'd5;
                4'b0110:          w_y = 3'd6;
                4'b1110, 4'b0001: w_y = 3'd7;
                4'b0111, 4'b1000: begin
                    w_y = 3'd7;
                    w_k = (w_x == 5'd23) || (w_x == 5'd27) || (w_x == 5'd29) || (w_x == 5'd30);
                end
                default:          w_4ok = 1'b0;
            endcase
        end

        if (w_n6 > 3'd3 || w_6b == 6'b000111)      w_rd6 = 1'b1;
        else if (w_n6 < 3'd3 || w_6b == 6'b111000) w_rd6 = 1'b0;
        else                                       w_rd6 = r_rd;
        if (w_n4 > 3'd2 || w_4b == 4'b0011)        w_rd4 = 1'b1;
        else if (w_n4 < 3'd2 || w_4b == 4'b1100)   w_rd4 = 1'b0;
        else                                       w_rd4 = w_rd6;

        w_dbad = (r_rd && (w_n6 > 3'd3 || w_6b == 6'b111000)) ||
                 (!r_rd && (w_n6 < 3'd3 || w_6b == 6'b000111)) ||
                 (w_rd6 && (w_n4 > 3'd2 || w_4b == 4'b1100)) ||
                 (!w_rd6 && (w_n4 < 3'd2 || w_4b == 4'b0011));
        w_sbad = !w_6ok || !w_4ok || (w_k28 && w_y == 3'd7);
    end

    assign w_byte     = {w_y, w_x};
    assign w_is_sync  = w_k && (w_byte == 8'h3C);
    assign w_is_eop   = w_k && (w_byte == 8'hBC);
    assign w_is_crcmk = w_k && (w_byte == 8'hF7);
    assign w_open     = (r_state == StData) || (r_state == StCrcb) || (r_state == StTerm);
    assign w_st       = startin ? StHunt : r_state;
    assign w_cnt      = startin ? '0 : r_cnt;
    assign w_cnt_inc  = w_cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StHunt;
            r_cnt      <= '0;
            r_rd       <= 1'b0;
            r_crc      <= CRC_INIT;
            r_rx_crc   <= '0;
            r_idx      <= '0;
            r_pushout  <= 1'b0;
            r_dataout  <= '0;
            r_startout <= 1'b0;
            r_endout   <= 1'b0;
            r_crc_err  <= 1'b0;
            r_sym_err  <= 1'b0;
            r_disp_err <= 1'b0;
        end else begin
            r_pushout  <= 1'b0;
            r_startout <= 1'b0;
            r_endout   <= 1'b0;
            r_crc_err  <= 1'b0;
            r_sym_err  <= 1'b0;
            r_disp_err <= 1'b0;
            if (pushin) begin
                r_rd       <= w_rd4;
                r_sym_err  <= w_sbad;
                r_disp_err <= w_dbad && !w_sbad;
                if ((startin || w_sbad) && w_open) begin
                    r_endout  <= 1'b1;
                    r_crc_err <= 1'b1;
                end
                if (w_sbad) begin
                    r_state <= StHunt;
                    r_cnt   <= '0;
                end else begin
                    case (w_st)
                        StHunt: begin
                            r_cnt   <= w_is_sync ? w_cnt_inc : '0;
                            r_state <= (w_is_sync && w_cnt_inc >= CW'(SYNC_LEN)) ? StSync : StHunt;
                        end
                        StSync: begin
                            if (w_is_eop || w_is_crcmk) begin
                                r_state <= StHunt;
                                r_cnt   <= '0;
                            end else if (!w_is_sync) begin
                                r_state    <= StData;
                                r_crc      <= crc32_byte(CRC_INIT, w_byte);
                                r_pushout  <= 1'b1;
                                r_startout <= 1'b1;
                                r_dataout  <= {w_k, w_byte};
                            end
                        end
                        StData: begin
                            if (w_is_crcmk) begin
                                r_state <= StCrcb;
                                r_idx   <= '0;
                            end else if (w_is_sync || w_is_eop) begin
                                // Sync inside a packet counts as the first of the next preamble
                                r_endout  <= 1'b1;
                                r_crc_err <= 1'b1;
                                r_state   <= StHunt;
                                r_cnt     <= w_is_sync ? CW'(1) : '0;
                            end else begin
                                r_crc     <= crc32_byte(r_crc, w_byte);
                                r_pushout <= 1'b1;
                                r_dataout <= {w_k, w_byte};
                            end
                        end
                        StCrcb: begin
                            if (w_k) begin
                                r_endout  <= 1'b1;
                                r_crc_err <= 1'b1;
                                r_state   <= StHunt;
                                r_cnt     <= '0;
                            end else begin
                                r_rx_crc[{r_idx, 3'b000} +: 8] <= w_byte;
                                r_idx <= r_idx + 2'd1;
                                if (r_idx == 2'd3) r_state <= StTerm;
                            end
                        end
                        StTerm: begin
                            r_endout  <= 1'b1;
                            r_crc_err <= !w_is_eop || (~r_crc != r_rx_crc);
                            r_state   <= StHunt;
                            r_cnt     <= '0;
                        end
                        default: begin
                            r_state <= StHunt;
                            r_cnt   <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign pushout  = r_pushout;
    assign dataout  = r_dataout;
    assign startout = r_startout;
    assign endout   = r_endout;
    assign crc_err  = r_crc_err;
    assign sym_err  = r_sym_err;
    assign disp_err = r_disp_err;
endmodule

// File: tb/tb_rx_8b10b_deframer.sv
// Bench for rx_8b10b_deframer: a local 8b/10b encoder builds directed packets, each symbol
// queues its expected output event, and a negedge monitor pops and compares.
module tb_rx_8b10b_deframer;
    typedef struct packed {
        logic       po;
        logic [8:0] d;
        logic       so;
        logic       eo;
        logic       ce;
        logic       se;
        logic       de;
    } ev_t;

    typedef struct {
        ev_t ev;
        int  tst;
    } item_t;

    localparam logic [5:0] T6 [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    localparam logic [3:0] T4 [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100,
                                      4'b1101, 4'b1010, 4'b0110, 4'b1110};
    localparam logic [3:0] T4K [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100,
                                       4'b1101, 4'b0101, 4'b1001, 4'b0111};
    localparam logic [7:0] MSG [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                                       8'h36, 8'h37, 8'h38, 8'h39};
    localparam logic [7:0] CRCB [4] = '{8'h26, 8'h39, 8'hF4, 8'hCB};

    logic       clk = 1'b0;
    logic       reset, pushin, startin;
    logic [9:0] datain;
    logic       pushout, startout, endout, crc_err, sym_err, disp_err;
    logic [8:0] dataout;

    item_t      exp_q[$];
    item_t      it;
    ev_t        got;
    int         checks = 0;
    int         errors = 0;
    int         cur_test = 0;
    logic       tb_rd;
    logic       gap_mode;

    always #5 clk = ~clk;

    rx_8b10b_deframer dut (
        .clk      (clk),
        .reset    (reset),
        .pushin   (pushin),
        .datain   (datain),
        .startin  (startin),
        .pushout  (pushout),
        .dataout  (dataout),
        .startout (startout),
        .endout   (endout),
        .crc_err  (crc_err),
        .sym_err  (sym_err),
        .disp_err (disp_err)
    );

    // Encoder: RD- tables, complemented at RD+ where the code is unbalanced (or D.7 / D.x.3)
    function automatic logic [9:0] enc(input logic k, input logic [7:0] b);
        logic [5:0] c6;
        logic [3:0] c4;
        logic [4:0] x;
        logic [2:0] y;
        logic       a7;
        x  = b[4:0];
        y  = b[7:5];
        c6 = (k && x == 5'd28) ? 6'b001111 : T6[x];
        if (tb_rd && ($countones(c6) != 3 || c6 == 6'b111000)) c6 = ~c6;
        if ($countones(c6) != 3) tb_rd = ~tb_rd;
        if (k) begin
            c4 = T4K[y];
        end else begin
            a7 = (y == 3'd7) && ((!tb_rd && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                                 (tb_rd && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
            c4 = a7 ? 4'b0111 : T4[y];
        end
        if (tb_rd && (k || $countones(c4) != 2 || c4 == 4'b1100)) c4 = ~c4;
        if ($countones(c4) != 2) tb_rd = ~tb_rd;
        return {c6, c4};
    endfunction

    function automatic void push_exp(input logic po, input logic [8:0] d, input logic so,
                                     input logic eo, input logic ce, input logic se,
                                     input logic de);
        item_t e;
        e.ev.po = po; e.ev.d = d; e.ev.so = so; e.ev.eo = eo;
        e.ev.ce = ce; e.ev.se = se; e.ev.de = de;
        e.tst = cur_test;
        exp_q.push_back(e);
    endfunction

    task automatic drive(input logic [9:0] s, input logic st);
        if (gap_mode) begin
            repeat ($urandom_range(0, 2)) begin
                datain = 10'($urandom);
                @(posedge clk); #1;
            end
        end
        pushin = 1'b1; startin = st; datain = s;
        @(posedge clk); #1;
        pushin = 1'b0; startin = 1'b0;
    endtask

    task automatic sym(input logic k, input logic [7:0] b, input logic out, input logic so);
        logic [9:0] s;
        s = enc(k, b);
        if (out) push_exp(1'b1, {k, b}, so, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(s, 1'b0);
    endtask

    task automatic sync(input int n);
        for (int i = 0; i < n; i++) sym(1'b1, 8'h3C, 1'b0, 1'b0);
    endtask

    task automatic msg(input int lo, input int hi, input int flip, input logic fwd,
                       input logic first);
        for (int i = lo; i <= hi; i++) begin
            sym(1'b0, MSG[i] ^ ((i == flip) ? 8'h01 : 8'h00), fwd, first && (i == lo));
        end
    endtask

    task automatic trailer(input logic fwd, input logic ce);
        sym(1'b1, 8'hF7, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) sym(1'b0, CRCB[i], 1'b0, 1'b0);
        if (fwd) push_exp(1'b0, 9'd0, 1'b0, 1'b1, ce, 1'b0, 1'b0);
        drive(enc(1'b1, 8'hBC), 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1; pushin = 1'b0; startin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        tb_rd = 1'b0;
    endtask

    always @(negedge clk) begin
        if (pushout || endout || sym_err || disp_err) begin
            got.po = pushout; got.d = pushout ? dataout : 9'd0; got.so = startout;
            got.eo = endout; got.ce = crc_err; got.se = sym_err; got.de = disp_err;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event test%0d: got po=%b d=%h so=%b eo=%b ce=%b se=%b de=%b, none required",
                         cur_test, got.po, got.d, got.so, got.eo, got.ce, got.se, got.de);
            end else begin
                it = exp_q.pop_front();
                if (got !== it.ev) begin
                    errors++;
                    $display("FAIL event test%0d: got po=%b d=%h so=%b eo=%b ce=%b se=%b de=%b, required po=%b d=%h so=%b eo=%b ce=%b se=%b de=%b",
                             it.tst, got.po, got.d, got.so, got.eo, got.ce, got.se, got.de,
                             it.ev.po, it.ev.d, it.ev.so, it.ev.eo, it.ev.ce, it.ev.se, it.ev.de);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; pushin = 1'b0; startin = 1'b0; datain = '0;
        gap_mode = 1'b0; tb_rd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({pushout, dataout, startout, endout, crc_err, sym_err, disp_err} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {pushout, dataout, startout, endout, crc_err, sym_err, disp_err});
        end
        @(posedge clk); #1;

        cur_test = 1;               // good packet, CRC 0xCBF43926
        sync(4); msg(0, 8, -1, 1'b1, 1'b1); trailer(1'b1, 1'b0);

        cur_test = 2;               // one payload bit flipped
        sync(4); msg(0, 8, 4, 1'b1, 1'b1); trailer(1'b1, 1'b1);

        cur_test = 3;               // short preamble rejected, long preamble accepted
        sync(3); msg(0, 1, -1, 1'b0, 1'b0);
        sync(5); msg(0, 8, -1, 1'b1, 1'b1); trailer(1'b1, 1'b0);

        cur_test = 4;               // startin aborts an open packet; its K.28.1 counts as sync 1
        sync(4); msg(0, 1, -1, 1'b1, 1'b1);
        push_exp(1'b0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(enc(1'b1, 8'h3C), 1'b1);
        sync(3); msg(0, 8, -1, 1'b1, 1'b1); trailer(1'b1, 1'b0);

        cur_test = 5;               // invalid code mid-payload; rest of packet ignored
        sync(4); msg(0, 2, -1, 1'b1, 1'b1);
        push_exp(1'b0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(10'b000000_1111, 1'b0);
        tb_rd = 1'b1;               // 000000 ends RD-, 1111 ends RD+
        msg(3, 8, -1, 1'b0, 1'b0); trailer(1'b0, 1'b0);

        cur_test = 6;               // reset mid-packet drops it silently
        sync(4); msg(0, 3, -1, 1'b1, 1'b1);
        do_reset();

        cur_test = 7;               // D.0.0 RD+ form while RD-: disparity error, byte kept
        sync(4);
        push_exp(1'b1, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(10'b011000_0100, 1'b0);
        msg(0, 8, -1, 1'b1, 1'b0); trailer(1'b1, 1'b1);

        cur_test = 8;               // good packet with random idle cycles
        gap_mode = 1'b1;
        sync(4); msg(0, 8, -1, 1'b1, 1'b1); trailer(1'b1, 1'b0);
        gap_mode = 1'b0;

        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: got %0d outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
